// File: rtl/lorenz_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lorenz_pkg
// Description : Shared definitions for the Lorenz-attractor solver: default
//               fixed-point geometry, saturation limits for the default
//               width, FSM state encoding and multiplier product select.
// Revision    : 1.0 - initial release
// ============================================================================
package lorenz_pkg;

    localparam int c_WIDTH_DEF = 27;
    localparam int c_FRAC_DEF  = 20;
    localparam int c_STEPW_DEF = 32;

    // Saturation limits for the default width; parametrised modules derive
    // their own limits from WIDTH in the same way.
    localparam logic signed [c_WIDTH_DEF-1:0] c_MAXV = {1'b0, {(c_WIDTH_DEF-1){1'b1}}};
    localparam logic signed [c_WIDTH_DEF-1:0] c_MINV = {1'b1, {(c_WIDTH_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MUL  = 2'd2,
        ST_UPD  = 2'd3
    } state_t;

    // Which product the shared multiplier computes in the current MUL cycle.
    typedef enum logic [1:0] {
        SEL_P0 = 2'd0,   // sigma * (y - x)
        SEL_P1 = 2'd1,   // x * (rho - z)
        SEL_P2 = 2'd2,   // x * y
        SEL_P3 = 2'd3    // beta * z
    } psel_t;

endpackage
`default_nettype wire

// File: rtl/lorenz_solver_fx_mult.sv
`default_nettype none
// ============================================================================
// Module      : fx_mult
// Description : Combinational signed fixed-point multiplier. Forms the full
//               2*WIDTH product, rescales by an arithmetic shift of FRAC and
//               clamps the result into WIDTH bits.
// Ports       : a, b  in  WIDTH  signed operands
//               p     out WIDTH  saturated, rescaled product
//               ovf   out 1      result was clamped
// Revision    : 1.0 - initial release
// ============================================================================
module fx_mult
    import lorenz_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEF,
    parameter int FRAC  = c_FRAC_DEF
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p,
    output logic                    ovf
);

    localparam logic signed [WIDTH-1:0]   c_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]   c_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    // The same limits sign-extended to the full product width.
    localparam logic signed [2*WIDTH-1:0] c_HI  = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] c_LO  = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] w_full;
    logic signed [2*WIDTH-1:0] w_shr;

    assign w_full = a * b;
    assign w_shr  = w_full >>> FRAC;
    assign ovf    = (w_shr > c_HI) || (w_shr < c_LO);
    assign p      = !ovf ? w_shr[WIDTH-1:0] : (w_shr[2*WIDTH-1] ? c_MIN : c_MAX);

endmodule
`default_nettype wire

// File: rtl/lorenz_solver.sv
`default_nettype none
// ============================================================================
// Module      : lorenz_solver
// Description : Run-controlled forward-Euler Lorenz integrator in signed
//               fixed point. One shared multiplier is time-multiplexed over
//               four MUL cycles, followed by one UPD cycle (5 cycles/step).
// Ports       : clk, reset              clock, synchronous active-high reset
//               start, stop             run control
//               sigma, beta, rho        coefficients (WIDTH, signed)
//               x0, y0, z0              initial conditions (WIDTH, signed)
//               dt_shift                dt = 2^-dt_shift
//               decim                   emit every decim-th step (0 -> 1)
//               steps                   step limit (0 = free run)
//               x, y, z                 registered state
//               out_valid               emitted-sample strobe
//               busy, done, sat         run status, completion pulse, sticky clamp
//               step_count              steps completed in current/last run
// Revision    : 1.0 - initial release
// ============================================================================
module lorenz_solver
    import lorenz_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEF,
    parameter int FRAC  = c_FRAC_DEF,
    parameter int STEPW = c_STEPW_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic signed [WIDTH-1:0] sigma,
    input  logic signed [WIDTH-1:0] beta,
    input  logic signed [WIDTH-1:0] rho,
    input  logic signed [WIDTH-1:0] x0,
    input  logic signed [WIDTH-1:0] y0,
    input  logic signed [WIDTH-1:0] z0,
    input  logic [4:0]              dt_shift,
    input  logic [15:0]             decim,
    input  logic [STEPW-1:0]        steps,
    output logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y,
    output logic signed [WIDTH-1:0] z,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    sat,
    output logic [STEPW-1:0]        step_count
);

    localparam logic signed [WIDTH-1:0] c_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] c_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Fit a WIDTH+1 intermediate into WIDTH bits. Returns {clamped, value}.
    function automatic logic [WIDTH:0] sat_fit(input logic signed [WIDTH:0] v);
        logic [WIDTH:0] r;
        if (v[WIDTH] != v[WIDTH-1]) begin
            r = {1'b1, (v[WIDTH] ? c_MIN : c_MAX)};
        end else begin
            r = {1'b0, v[WIDTH-1:0]};
        end
        return r;
    endfunction

    function automatic logic [WIDTH:0] sat_sub(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH:0] v;
        v = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        return sat_fit(v);
    endfunction

    function automatic logic [WIDTH:0] sat_add(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH:0] v;
        v = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        return sat_fit(v);
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_state_nxt;
    psel_t                   r_k;

    logic signed [WIDTH-1:0] r_x, r_y, r_z;
    logic signed [WIDTH-1:0] r_sigma, r_beta, r_rho;
    logic [4:0]              r_dt;
    logic [15:0]             r_decim;
    logic [STEPW-1:0]        r_steps;
    logic signed [WIDTH-1:0] r_p0, r_p1, r_p2, r_p3;
    logic [STEPW-1:0]        r_step_count;
    logic [15:0]             r_dec_cnt;
    logic                    r_sat;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_out_valid;
    logic                    r_stop_pend;

    // ------------------------------------------------------------------
    // Multiplier operand selection
    // ------------------------------------------------------------------
    logic [WIDTH:0]          w_yx_r, w_rz_r;
    logic signed [WIDTH-1:0] w_ma, w_mb, w_mprod;
    logic                    w_movf;
    logic                    w_sub_sat;
    logic                    w_mul_sat;

    assign w_yx_r = sat_sub(r_y, r_x);
    assign w_rz_r = sat_sub(r_rho, r_z);

    always_comb begin
        w_ma      = r_sigma;
        w_mb      = w_yx_r[WIDTH-1:0];
        w_sub_sat = 1'b0;
        case (r_k)
            SEL_P0: begin
                w_ma      = r_sigma;
                w_mb      = w_yx_r[WIDTH-1:0];
                w_sub_sat = w_yx_r[WIDTH];
            end
            SEL_P1: begin
                w_ma      = r_x;
                w_mb      = w_rz_r[WIDTH-1:0];
                w_sub_sat = w_rz_r[WIDTH];
            end
            SEL_P2: begin
                w_ma = r_x;
                w_mb = r_y;
            end
            SEL_P3: begin
                w_ma = r_beta;
                w_mb = r_z;
            end
            default: begin
                w_ma = r_sigma;
            end
        endcase
    end

    fx_mult #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mult (
        .a   (w_ma),
        .b   (w_mb),
        .p   (w_mprod),
        .ovf (w_movf)
    );

    assign w_mul_sat = w_movf | w_sub_sat;

    // ------------------------------------------------------------------
    // Euler update
    // ------------------------------------------------------------------
    logic [WIDTH:0]          w_dy_r, w_dz_r;
    logic signed [WIDTH-1:0] w_dy, w_dz;
    logic signed [WIDTH-1:0] w_sx, w_sy, w_sz;
    logic [WIDTH:0]          w_xn_r, w_yn_r, w_zn_r;
    logic                    w_upd_sat;

    assign w_dy_r = sat_sub(r_p1, r_y);
    assign w_dz_r = sat_sub(r_p2, r_p3);
    assign w_dy   = w_dy_r[WIDTH-1:0];
    assign w_dz   = w_dz_r[WIDTH-1:0];

    // Scaling by dt is an arithmetic right shift (rounds toward -inf).
    assign w_sx   = r_p0 >>> r_dt;
    assign w_sy   = w_dy >>> r_dt;
    assign w_sz   = w_dz >>> r_dt;

    assign w_xn_r = sat_add(r_x, w_sx);
    assign w_yn_r = sat_add(r_y, w_sy);
    assign w_zn_r = sat_add(r_z, w_sz);

    assign w_upd_sat = w_dy_r[WIDTH] | w_dz_r[WIDTH] |
                       w_xn_r[WIDTH] | w_yn_r[WIDTH] | w_zn_r[WIDTH];

    // ------------------------------------------------------------------
    // Run control
    // ------------------------------------------------------------------
    logic [STEPW-1:0] w_cnt_inc;
    logic             w_limit_hit;
    logic             w_finish;
    logic [15:0]      w_decim_eff;
    logic [15:0]      w_dec_inc;
    logic             w_emit;

    assign w_cnt_inc   = r_step_count + STEPW'(1);
    assign w_limit_hit = (r_steps != '0) && (w_cnt_inc == r_steps);
    // A stop seen in the UPD cycle itself ends the run at this update.
    assign w_finish    = w_limit_hit || r_stop_pend || stop;

    // Decimation uses a wrap counter instead of a modulo on step_count.
    assign w_decim_eff = (r_decim == 16'd0) ? 16'd1 : r_decim;
    assign w_dec_inc   = r_dec_cnt + 16'd1;
    assign w_emit      = (w_dec_inc == w_decim_eff);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_MUL;
            end
            ST_MUL: begin
                if (r_k == SEL_P3) begin
                    w_state_nxt = ST_UPD;
                end
            end
            ST_UPD: begin
                w_state_nxt = w_finish ? ST_IDLE : ST_MUL;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k          <= SEL_P0;
            r_x          <= '0;
            r_y          <= '0;
            r_z          <= '0;
            r_sigma      <= '0;
            r_beta       <= '0;
            r_rho        <= '0;
            r_dt         <= '0;
            r_decim      <= '0;
            r_steps      <= '0;
            r_p0         <= '0;
            r_p1         <= '0;
            r_p2         <= '0;
            r_p3         <= '0;
            r_step_count <= '0;
            r_dec_cnt    <= '0;
            r_sat        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_stop_pend  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    r_sigma      <= sigma;
                    r_beta       <= beta;
                    r_rho        <= rho;
                    r_dt         <= dt_shift;
                    r_decim      <= decim;
                    r_steps      <= steps;
                    r_x          <= x0;
                    r_y          <= y0;
                    r_z          <= z0;
                    r_step_count <= '0;
                    r_dec_cnt    <= '0;
                    r_sat        <= 1'b0;
                    r_busy       <= 1'b1;
                    r_out_valid  <= 1'b1;
                    r_stop_pend  <= stop;
                    r_k          <= SEL_P0;
                end
                ST_MUL: begin
                    case (r_k)
                        SEL_P0:  r_p0 <= w_mprod;
                        SEL_P1:  r_p1 <= w_mprod;
                        SEL_P2:  r_p2 <= w_mprod;
                        default: r_p3 <= w_mprod;
                    endcase
                    if (w_mul_sat) begin
                        r_sat <= 1'b1;
                    end
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    r_k <= psel_t'(r_k + 2'd1);
                end
                ST_UPD: begin
                    r_x          <= w_xn_r[WIDTH-1:0];
                    r_y          <= w_yn_r[WIDTH-1:0];
                    r_z          <= w_zn_r[WIDTH-1:0];
                    r_step_count <= w_cnt_inc;
                    r_dec_cnt    <= w_emit ? 16'd0 : w_dec_inc;
                    if (w_upd_sat) begin
                        r_sat <= 1'b1;
                    end
                    r_out_valid  <= w_emit | w_finish;
                    r_k          <= SEL_P0;
                    if (w_finish) begin
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_stop_pend <= 1'b0;
                    end
                end
                default: begin
                    r_k <= SEL_P0;
                end
            endcase
        end
    end

    assign x          = r_x;
    assign y          = r_y;
    assign z          = r_z;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sat        = r_sat;
    assign step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_lorenz_solver.sv
`default_nettype none
// ============================================================================
// Module      : tb_lorenz_solver
// Description : Directed self-checking bench for lorenz_solver
//               (WIDTH=27, FRAC=20, STEPW=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lorenz_solver;

    localparam int     WIDTH = 27;
    localparam int     FRAC  = 20;
    localparam int     STEPW = 32;
    localparam int     ONE   = 1 << FRAC;
    localparam longint MAXV  = 67108863;
    localparam longint MINV  = -67108864;

    logic                    clk = 1'b0;
    logic                    reset, start, stop;
    logic signed [WIDTH-1:0] sigma, beta, rho, x0, y0, z0;
    logic [4:0]              dt_shift;
    logic [15:0]             decim;
    logic [STEPW-1:0]        steps;
    logic signed [WIDTH-1:0] x, y, z;
    logic                    out_valid, busy, done, sat;
    logic [STEPW-1:0]        step_count;

    int n_vec = 0;
    int n_err = 0;

    lorenz_solver #(.WIDTH(WIDTH), .FRAC(FRAC), .STEPW(STEPW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .sigma(sigma), .beta(beta), .rho(rho),
        .x0(x0), .y0(y0), .z0(z0),
        .dt_shift(dt_shift), .decim(decim), .steps(steps),
        .x(x), .y(y), .z(z),
        .out_valid(out_valid), .busy(busy), .done(done), .sat(sat),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the start edge (state LOAD).
    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_unit(input logic [STEPW-1:0] n, input logic [15:0] d);
        sigma = '0; beta = '0; rho = '0;
        x0 = ONE; y0 = ONE; z0 = ONE;
        dt_shift = 5'd8; decim = d; steps = n;
    endtask

    // Reference arithmetic for the golden run.
    function automatic longint clampv(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic longint fmul(input longint a, input longint b);
        return clampv((a * b) >>> FRAC);
    endfunction

    task automatic test_reset();
        n_vec++;
        if ({x, y, z} !== '0) begin
            n_err++; $display("FAIL reset_xyz: got %0d/%0d/%0d expected 0/0/0", x, y, z);
        end
        n_vec++;
        if ({busy, done, out_valid, sat} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, out_valid, sat});
        end
        n_vec++;
        if (step_count !== '0) begin
            n_err++; $display("FAIL reset_count: got %0d expected 0", step_count);
        end
        // Reset in the middle of a free run.
        set_unit(0, 16'd1);
        go();
        repeat (8) tick();
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL reset_prerun_busy: got %b expected 1", busy);
        end
        reset = 1'b1;
        tick();
        n_vec++;
        if ({x, y, z, busy, done, out_valid, sat, step_count} !== '0) begin
            n_err++; $display("FAIL reset_midrun: x=%0d y=%0d z=%0d b/d/v/s=%b cnt=%0d expected all 0",
                              x, y, z, {busy, done, out_valid, sat}, step_count);
        end
        tick();
        reset = 1'b0;
        repeat (6) tick();
        n_vec++;
        if ({busy, out_valid, step_count, x} !== '0) begin
            n_err++; $display("FAIL reset_stays_idle: busy=%b ov=%b cnt=%0d x=%0d expected 0",
                              busy, out_valid, step_count, x);
        end
    endtask

    task automatic test_single_step();
        int ov_base;
        set_unit(1, 16'd1);
        ov_base = 0;
        go();
        tick();                                   // E1
        n_vec++;
        if ({x, y, z} !== {27'sd1048576, 27'sd1048576, 27'sd1048576}) begin
            n_err++; $display("FAIL single_load_xyz: got %0d/%0d/%0d expected 1048576 each", x, y, z);
        end
        n_vec++;
        if ({out_valid, busy, done} !== 3'b110) begin
            n_err++; $display("FAIL single_load_flags: got ov/busy/done=%b expected 110", {out_valid, busy, done});
        end
        ov_base = 1;
        repeat (4) tick();                        // E5
        n_vec++;
        if ({busy, done, out_valid} !== 3'b100 || step_count !== 0) begin
            n_err++; $display("FAIL single_e5: got b/d/v=%b cnt=%0d expected 100 cnt 0",
                              {busy, done, out_valid}, step_count);
        end
        tick();                                   // E6
        // dx = 0; dy = 1.0*(0-1.0) - 1.0 = -2.0 -> -2^21>>>8 = -8192;
        // dz = 1.0*1.0 - 0 = 1.0 -> 2^20>>>8 = +4096.
        n_vec++;
        if (x !== 27'sd1048576) begin
            n_err++; $display("FAIL single_x: got %0d expected 1048576", x);
        end
        n_vec++;
        if (y !== 27'sd1040384) begin
            n_err++; $display("FAIL single_y: got %0d expected 1040384", y);
        end
        n_vec++;
        if (z !== 27'sd1052672) begin
            n_err++; $display("FAIL single_z: got %0d expected 1052672", z);
        end
        n_vec++;
        if ({done, busy, out_valid} !== 3'b101 || step_count !== 1) begin
            n_err++; $display("FAIL single_end: got d/b/v=%b cnt=%0d expected 101 cnt 1",
                              {done, busy, out_valid}, step_count);
        end
        if (out_valid) ov_base++;
        tick();
        if (out_valid) ov_base++;
        n_vec++;
        if (done !== 1'b0 || ov_base !== 2) begin
            n_err++; $display("FAIL single_pulses: got done=%b ov_pulses=%0d expected 0 and 2", done, ov_base);
        end
    endtask

    task automatic test_decimation();
        logic [63:0] ov_mask, dn_mask, ov_exp, dn_exp;
        ov_mask = '0; dn_mask = '0; ov_exp = '0; dn_exp = '0;
        ov_exp[1] = 1'b1; ov_exp[16] = 1'b1; ov_exp[31] = 1'b1; ov_exp[36] = 1'b1;
        dn_exp[36] = 1'b1;
        set_unit(7, 16'd3);
        go();
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (out_valid) ov_mask[c] = 1'b1;
            if (done) dn_mask[c] = 1'b1;
        end
        n_vec++;
        if (ov_mask !== ov_exp) begin
            n_err++; $display("FAIL decim_valid_edges: got %h expected %h", ov_mask, ov_exp);
        end
        n_vec++;
        if (dn_mask !== dn_exp) begin
            n_err++; $display("FAIL decim_done_edge: got %h expected %h", dn_mask, dn_exp);
        end
        n_vec++;
        if (step_count !== 7 || busy !== 1'b0) begin
            n_err++; $display("FAIL decim_final: got cnt=%0d busy=%b expected 7 and 0", step_count, busy);
        end
    endtask

    task automatic test_free_run_stop();
        logic [63:0] dn_mask, dn_exp;
        dn_mask = '0; dn_exp = '0; dn_exp[21] = 1'b1;
        set_unit(0, 16'd1);
        go();
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done) dn_mask[c] = 1'b1;
            if (c == 8) start = 1'b1;             // sampled mid-run, must be ignored
            if (c == 9) start = 1'b0;
            if (c == 11) begin
                n_vec++;
                if (step_count !== 2 || busy !== 1'b1) begin
                    n_err++; $display("FAIL freerun_start_ignored: got cnt=%0d busy=%b expected 2 and 1",
                                      step_count, busy);
                end
            end
            if (c == 17) stop = 1'b1;             // sampled in a MUL cycle of step 4
            if (c == 18) stop = 1'b0;
        end
        n_vec++;
        if (dn_mask !== dn_exp) begin
            n_err++; $display("FAIL freerun_done_edge: got %h expected %h", dn_mask, dn_exp);
        end
        n_vec++;
        if (step_count !== 4 || busy !== 1'b0) begin
            n_err++; $display("FAIL freerun_count: got cnt=%0d busy=%b expected 4 and 0", step_count, busy);
        end
    endtask

    task automatic test_stop_and_limit();
        logic [63:0] dn_mask, dn_exp;
        dn_mask = '0; dn_exp = '0; dn_exp[11] = 1'b1;
        set_unit(2, 16'd1);
        go();
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (done) dn_mask[c] = 1'b1;
            if (c == 7) stop = 1'b1;
            if (c == 8) stop = 1'b0;
        end
        n_vec++;
        if (dn_mask !== dn_exp || step_count !== 2) begin
            n_err++; $display("FAIL stop_limit_single_done: got mask=%h cnt=%0d expected %h cnt 2",
                              dn_mask, step_count, dn_exp);
        end
    endtask

    task automatic test_saturation();
        // sigma=-10.0 drives x above full scale: y-x clamps to MIN,
        // p0 = -10*MIN clamps to MAX, x+MAX>>>8 clamps to MAX.
        // y: dy = 0 - MIN clamps to MAX -> y = MIN + 262143.
        // z: p2 = x*y clamps to MIN -> z = MIN>>>8 = -262144.
        sigma = -27'sd10485760; beta = '0; rho = '0;
        x0 = 27'sd67108863; y0 = -27'sd67108864; z0 = '0;
        dt_shift = 5'd8; decim = 16'd1; steps = 1;
        go();
        repeat (6) tick();                        // E6
        n_vec++;
        if (x !== 27'sd67108863) begin
            n_err++; $display("FAIL sat_x_clamp: got %0d expected 67108863", x);
        end
        n_vec++;
        if (y !== -27'sd66846721 || z !== -27'sd262144) begin
            n_err++; $display("FAIL sat_yz: got %0d/%0d expected -66846721/-262144", y, z);
        end
        n_vec++;
        if (sat !== 1'b1 || done !== 1'b1) begin
            n_err++; $display("FAIL sat_flag: got sat=%b done=%b expected 1 and 1", sat, done);
        end
        repeat (4) tick();
        n_vec++;
        if (sat !== 1'b1) begin
            n_err++; $display("FAIL sat_sticky_idle: got %b expected 1", sat);
        end
        set_unit(1, 16'd1);
        go();
        tick();                                   // E1 of a benign run
        n_vec++;
        if (sat !== 1'b0) begin
            n_err++; $display("FAIL sat_clear_on_load: got %b expected 0", sat);
        end
        repeat (6) tick();
        n_vec++;
        if (sat !== 1'b0 || step_count !== 1) begin
            n_err++; $display("FAIL sat_benign_run: got sat=%b cnt=%0d expected 0 cnt 1", sat, step_count);
        end
    endtask

    task automatic test_golden();
        longint mx, my, mz, sg, bt, rh;
        longint p0, p1, p2, p3, dy, dz, nx, ny, nz;
        int     ns;
        bit     fin;
        sg = 10485760; bt = 2796203; rh = 29360128;
        mx = -1048576; my = 104858; mz = 26214400;
        sigma = 27'(sg); beta = 27'(bt); rho = 27'(rh);
        x0 = 27'(mx); y0 = 27'(my); z0 = 27'(mz);
        dt_shift = 5'd8; decim = 16'd0; steps = 1000;
        ns = 0; fin = 1'b0;
        go();
        for (int c = 1; c <= 5100 && !fin; c++) begin
            tick();
            if (out_valid) begin
                if (ns > 0) begin
                    p0 = fmul(sg, clampv(my - mx));
                    p1 = fmul(mx, clampv(rh - mz));
                    p2 = fmul(mx, my);
                    p3 = fmul(bt, mz);
                    dy = clampv(p1 - my);
                    dz = clampv(p2 - p3);
                    nx = clampv(mx + (p0 >>> 8));
                    ny = clampv(my + (dy >>> 8));
                    nz = clampv(mz + (dz >>> 8));
                    mx = nx; my = ny; mz = nz;
                end
                n_vec++;
                if (longint'(x) != mx || longint'(y) != my || longint'(z) != mz) begin
                    n_err++; $display("FAIL golden_sample %0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                                      ns, x, y, z, mx, my, mz);
                end
                ns++;
            end
            if (done) fin = 1'b1;
        end
        n_vec++;
        if (!fin || ns != 1001 || step_count !== 1000) begin
            n_err++; $display("FAIL golden_run_end: got done_seen=%b samples=%0d cnt=%0d expected 1, 1001, 1000",
                              fin, ns, step_count);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        set_unit(1, 16'd1);
        repeat (2) tick();
        reset = 1'b0;
        test_reset();
        test_single_step();
        test_decimation();
        test_free_run_stop();
        test_stop_and_limit();
        test_saturation();
        test_golden();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
